// File: rtl/pager_mem_cycle.sv
// Checks a paged memory access and either raises a page fail or runs one bus cycle, with NXM timeout.
// PDP-10 bit numbering on ports: bit [0] is the MSB (vmaREG[0] = vmaREG[35] here, pageFLAGS[0] = pageFLAGS[3]).
module pager_mem_cycle #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNTW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  logic        cycleSTART,
  input  logic        failCLR,
  input  logic        pagingEN,
  input  logic [35:0] vmaREG,
  input  logic [3:0]  pageFLAGS,
  input  logic [10:0] pageADDR,
  input  logic        busACK,
  output logic        busREQ,
  output logic [19:0] busADDR,
  output logic [3:0]  busFLAGS,
  output logic        memWAIT,
  output logic        memDONE,
  output logic        pageFAIL,
  output logic [3:0]  pageFAILCODE
);

  typedef enum logic [2:0] {IDLE, CHECK, REQ, DONE, FAIL} state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [19:0]     addr_q, addr_d;
  logic [3:0]      flags_q, flags_d;
  logic [3:0]      code_q, code_d;

  logic vma_user, vma_read, vma_wrtest, vma_write, vma_phys, vma_io;
  logic pg_valid, pg_wr, pg_cache, pg_user;
  logic mapped, nv, wp, um, fault;
  logic unused_vma;

  assign vma_user   = vmaREG[35];
  assign vma_read   = vmaREG[32];
  assign vma_wrtest = vmaREG[31];
  assign vma_write  = vmaREG[30];
  assign vma_phys   = vmaREG[27];
  assign vma_io     = vmaREG[25];
  assign unused_vma = ^{vmaREG[34:33], vmaREG[29:28], vmaREG[26], vmaREG[24:20]};

  assign pg_valid = pageFLAGS[3];
  assign pg_wr    = pageFLAGS[2];
  assign pg_cache = pageFLAGS[1];
  assign pg_user  = pageFLAGS[0];

  assign mapped = pagingEN & ~vma_phys & ~vma_io;
  assign nv     = mapped & ~pg_valid;
  assign wp     = mapped & (vma_write | vma_wrtest) & ~pg_wr;
  assign um     = mapped & (vma_user != pg_user);
  assign fault  = nv | wp | um;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    flags_d = flags_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (clken && cycleSTART) state_d = CHECK;
      end
      CHECK: begin
        if (fault) begin
          state_d = FAIL;
          code_d  = {nv, wp, um, 1'b0};
        end else begin
          state_d = REQ;
          cnt_d   = '0;
          addr_d  = mapped ? {pageADDR, vmaREG[8:0]} : vmaREG[19:0];
          flags_d = {vma_read, vma_write, vma_io, mapped & pg_cache};
        end
      end
      REQ: begin
        // An ack on the timeout clock still completes the cycle.
        if (busACK) begin
          state_d = DONE;
        end else if (cnt_q == CNTW'(TIMEOUT)) begin
          state_d = FAIL;
          code_d  = 4'b0001;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      FAIL: begin
        if (clken && failCLR) begin
          state_d = IDLE;
          code_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      flags_q <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      flags_q <= flags_d;
      code_q  <= code_d;
    end
  end

  assign busREQ       = (state_q == REQ);
  assign busADDR      = addr_q;
  assign busFLAGS     = flags_q;
  assign memWAIT      = (state_q == CHECK) || (state_q == REQ);
  assign memDONE      = (state_q == DONE);
  assign pageFAIL     = (state_q == FAIL);
  assign pageFAILCODE = code_q;

endmodule

// File: tb/tb_pager_mem_cycle.sv
// Bench for pager_mem_cycle: directed vector table, random transactions against a transaction-level model,
// and hand sequences for reset abort and clock-enable gating.
module tb_pager_mem_cycle;
  localparam int TO = 8;

  logic        clk = 0;
  logic        rst, clken, cycleSTART, failCLR, pagingEN, busACK;
  logic [35:0] vmaREG;
  logic [3:0]  pageFLAGS;
  logic [10:0] pageADDR;
  logic        busREQ, memWAIT, memDONE, pageFAIL;
  logic [19:0] busADDR;
  logic [3:0]  busFLAGS, pageFAILCODE;

  int checks = 0;
  int errors = 0;

  pager_mem_cycle #(.TIMEOUT(TO), .CNTW(10)) dut (
    .clk(clk), .rst(rst), .clken(clken), .cycleSTART(cycleSTART), .failCLR(failCLR),
    .pagingEN(pagingEN), .vmaREG(vmaREG), .pageFLAGS(pageFLAGS), .pageADDR(pageADDR),
    .busACK(busACK), .busREQ(busREQ), .busADDR(busADDR), .busFLAGS(busFLAGS),
    .memWAIT(memWAIT), .memDONE(memDONE), .pageFAIL(pageFAIL), .pageFAILCODE(pageFAILCODE)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // PDP-10 numbering: bit k counts from the MSB.
  function automatic logic [35:0] pbit(input int k);
    return 36'd1 << (35 - k);
  endfunction

  function automatic bit vb(input logic [35:0] v, input int k);
    return v[35-k];
  endfunction

  function automatic bit fb(input logic [3:0] f, input int k);
    return f[3-k];
  endfunction

  // Outcome of a whole access from the access rules; ack_at is the REQ clock (0-based) on which ack is given.
  function automatic void model(input logic pg, input logic [35:0] v, input logic [3:0] pf,
                                input logic [10:0] pa, input int ack_at,
                                output logic [3:0] code, output logic [19:0] addr,
                                output logic [3:0] fl, output int nreq);
    bit mapped, nv, wp, um;
    logic [35:0] a;
    mapped = pg && !vb(v, 8) && !vb(v, 10);
    nv = mapped && !fb(pf, 0);
    wp = mapped && (vb(v, 5) || vb(v, 4)) && !fb(pf, 1);
    um = mapped && (vb(v, 0) != fb(pf, 3));
    a  = mapped ? (36'(pa) * 512 + v % 512) : v % 36'h100000;
    addr = a[19:0];
    fl = {vb(v, 3), vb(v, 5), vb(v, 10), mapped && fb(pf, 2)};
    if (nv || wp || um) begin
      code = {nv, wp, um, 1'b0};
      nreq = 0;
    end else if (ack_at <= TO) begin
      code = 4'b0000;
      nreq = ack_at + 1;
    end else begin
      code = 4'b0001;
      nreq = TO + 1;
    end
  endfunction

  task automatic run_txn(input string tag, input logic pg, input logic [35:0] v, input logic [3:0] pf,
                         input logic [10:0] pa, input int ack_at, input bit hold,
                         input logic [3:0] e_code, input logic [19:0] e_addr,
                         input logic [3:0] e_flags, input int e_nreq);
    int nreq;
    bit done, fail, wait_bad;
    pagingEN = pg; vmaREG = v; pageFLAGS = pf; pageADDR = pa;
    busACK = 0; cycleSTART = 1;
    @(posedge clk); #1;
    cycleSTART = hold;
    chk({tag, ".wait_in_check"}, memWAIT, 1);
    @(posedge clk); #1;
    cycleSTART = 0;
    nreq = 0; done = 0; fail = 0; wait_bad = 0;
    for (int cyc = 0; cyc < 40 && !done && !fail; cyc++) begin
      if (memDONE) done = 1;
      else if (pageFAIL) fail = 1;
      else begin
        if (busREQ) begin
          if (!memWAIT) wait_bad = 1;
          busACK = (nreq == ack_at);
          nreq++;
        end else wait_bad = 1;
        @(posedge clk); #1;
      end
    end
    busACK = 0;
    chk({tag, ".req_clks"}, nreq, e_nreq);
    chk({tag, ".outcome"}, done ? 1 : (fail ? 2 : 0), (e_code == 0) ? 1 : 2);
    chk({tag, ".code"}, pageFAILCODE, e_code);
    chk({tag, ".wait_end"}, {memWAIT, wait_bad}, 0);
    if (e_nreq > 0) begin
      chk({tag, ".addr"}, busADDR, e_addr);
      chk({tag, ".flags"}, busFLAGS, e_flags);
    end
    if (fail) begin
      failCLR = 1; clken = 0;
      @(posedge clk); #1;
      chk({tag, ".clr_gated"}, pageFAIL, 1);
      clken = 1;
      @(posedge clk); #1;
      failCLR = 0;
      chk({tag, ".cleared"}, {pageFAIL, pageFAILCODE, memWAIT}, 0);
    end else if (done) begin
      @(posedge clk); #1;
      chk({tag, ".done_pulse"}, {memDONE, memWAIT, busREQ}, 0);
    end
  endtask

  typedef struct {
    logic        pg;
    logic [35:0] vma;
    logic [3:0]  pf;
    logic [10:0] pa;
    int          ack_at;
    logic [3:0]  e_code;
    logic [19:0] e_addr;
    logic [3:0]  e_flags;
    int          e_nreq;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [63:0] r;
    logic [3:0]  m_code, m_flags;
    logic [19:0] m_addr;
    int          m_nreq, ack, viol;

    // {pg, vma, pageFLAGS {V,W,C,U}, pageADDR, ack clk} -> {code, busADDR, busFLAGS, busREQ clks}
    vecs[0]  = '{1'b1, pbit(0) | pbit(3) | 36'o123456, 4'b1111, 11'o3777, 3, 4'b0000, 20'hFFF2E, 4'b1001, 4};
    vecs[1]  = '{1'b1, pbit(5) | 36'o100, 4'b1000, 11'h001, 0, 4'b0100, 20'h0, 4'b0, 0};
    vecs[2]  = '{1'b1, pbit(0) | pbit(3) | 36'o777, 4'b0100, 11'h002, 0, 4'b1010, 20'h0, 4'b0, 0};
    vecs[3]  = '{1'b1, pbit(8) | pbit(3) | 36'o765432, 4'b0010, 11'h7FF, 0, 4'b0000, 20'o765432, 4'b1000, 1};
    vecs[4]  = '{1'b0, pbit(3) | 36'o1234, 4'b0000, 11'h000, 99, 4'b0001, 20'o1234, 4'b1000, 9};
    vecs[5]  = '{1'b0, pbit(3) | 36'o1234, 4'b0000, 11'h000, 8, 4'b0000, 20'o1234, 4'b1000, 9};
    vecs[6]  = '{1'b1, pbit(10) | pbit(5) | 36'o7, 4'b0000, 11'h0, 1, 4'b0000, 20'o7, 4'b0110, 2};
    vecs[7]  = '{1'b1, pbit(4) | 36'o100, 4'b1010, 11'h3, 0, 4'b0100, 20'h0, 4'b0, 0};
    vecs[8]  = '{1'b1, pbit(4) | 36'o100, 4'b1110, 11'h3, 2, 4'b0000, 20'h640, 4'b0001, 3};
    vecs[9]  = '{1'b1, pbit(5), 4'b0001, 11'h5, 0, 4'b1110, 20'h0, 4'b0, 0};
    vecs[10] = '{1'b1, pbit(0) | pbit(5) | pbit(8) | 36'o55, 4'b0000, 11'h0, 0, 4'b0000, 20'o55, 4'b0100, 1};

    rst = 1; clken = 1; cycleSTART = 0; failCLR = 0; pagingEN = 0; busACK = 0;
    vmaREG = '0; pageFLAGS = '0; pageADDR = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busREQ, memWAIT, memDONE, pageFAIL, pageFAILCODE, busFLAGS}, 0);
    chk("reset_addr", busADDR, 0);
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].pg, vecs[i].vma, vecs[i].pf, vecs[i].pa, vecs[i].ack_at,
              1'b0, vecs[i].e_code, vecs[i].e_addr, vecs[i].e_flags, vecs[i].e_nreq);

    // Extra cycleSTART during CHECK must not disturb or restart the access.
    run_txn("hold_start", vecs[0].pg, vecs[0].vma, vecs[0].pf, vecs[0].pa, vecs[0].ack_at,
            1'b1, vecs[0].e_code, vecs[0].e_addr, vecs[0].e_flags, vecs[0].e_nreq);

    // cycleSTART without clken is ignored.
    clken = 0; cycleSTART = 1; vmaREG = pbit(3);
    repeat (2) @(posedge clk);
    #1;
    chk("clken_gates_start", {memWAIT, busREQ}, 0);
    cycleSTART = 0; clken = 1;

    for (int i = 0; i < 40; i++) begin
      r = {$urandom, $urandom};
      ack = $urandom_range(0, 10);
      pagingEN = ($urandom % 4) != 0;
      pageFLAGS = 4'($urandom);
      pageADDR = 11'($urandom);
      model(pagingEN, r[35:0], pageFLAGS, pageADDR, ack, m_code, m_addr, m_flags, m_nreq);
      run_txn($sformatf("rnd%0d", i), pagingEN, r[35:0], pageFLAGS, pageADDR, ack,
              1'($urandom), m_code, m_addr, m_flags, m_nreq);
    end

    // Reset in the middle of a bus cycle aborts it silently.
    pagingEN = 0; vmaREG = pbit(3) | 36'o4321; cycleSTART = 1; busACK = 0;
    @(posedge clk); #1;
    cycleSTART = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_in_req", busREQ, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_outputs", {busREQ, memWAIT, pageFAIL, memDONE}, 0);
    chk("abort_addr", busADDR, 0);
    viol = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (busREQ || memDONE || pageFAIL || memWAIT) viol++;
    end
    chk("abort_quiet", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
